// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : uart_pkg                                                   |
// | Purpose : Shared UART constants (data width, LSR bit positions) and  |
// |           a round-robin pointer helper.                              |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // LSR bit positions, shared with the MMIO slave.
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // Next round-robin start position after requester idx was served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                               |
// | Purpose : Synchronous FIFO with level/full/empty status. Read data   |
// |           is the head entry, valid whenever o_empty is low.          |
// | Ports   : clk, rst (async, active-high)                              |
// |           i_push/i_wdata  write side (ignored when full)             |
// |           i_pop/o_rdata   read side  (ignored when empty)            |
// |           o_full, o_empty, o_level  occupancy status                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_sched                                              |
// | Purpose : Shares the UART TX PHY among NREQ byte producers. A        |
// |           round-robin arbiter feeds a DEPTH-entry FIFO which drains  |
// |           through a registered valid/ready stage to the PHY.         |
// | Ports   : clka, rst (async, active-high)                             |
// |           req_data/req_valid/req_ready  producer side, one-hot grant |
// |           tx_data/tx_valid/tx_ready     PHY side                     |
// |           fifo_level, fifo_full, tx_idle  status for LSR THRE/TEMT   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                        clka,
  input  logic                        rst,
  input  logic [NREQ*UART_DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]      tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [LVL_W-1:0]            fifo_level,
  output logic                        fifo_full,
  output logic                        tx_idle
);

  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RR_W-1:0]        r_rr_ptr;
  logic                   r_tx_valid;
  logic [UART_DATA_W-1:0] r_tx_data;

  logic [NREQ-1:0]        w_grant;
  logic                   w_hit_lo;
  logic                   w_hit_hi;
  logic [RR_W-1:0]        w_idx_lo;
  logic [RR_W-1:0]        w_idx_hi;
  logic [RR_W-1:0]        w_gidx;
  logic                   w_push;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_wdata;
  logic [UART_DATA_W-1:0] w_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  // Round-robin search without modulo: the lowest valid index at or above
  // r_rr_ptr wins; failing that, the lowest valid index overall (wrap).
  // Descending loop so the lowest index overwrites last.
  always_comb begin
    w_grant  = '0;
    w_hit_lo = 1'b0;
    w_hit_hi = 1'b0;
    w_idx_lo = '0;
    w_idx_hi = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = RR_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hit_hi = 1'b1;
          w_idx_hi = RR_W'(i);
        end
      end
    end
    w_gidx = w_hit_hi ? w_idx_hi : w_idx_lo;
    // No grant at full, even if the output stage pops this cycle.
    if (w_hit_lo && !w_fifo_full) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_wdata = req_data[UART_DATA_W*i +: UART_DATA_W];
    end
  end

  assign w_push = |w_grant;
  assign w_pop  = ~w_fifo_empty & (~r_tx_valid | tx_ready);

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clka),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  // Output register: refills from the FIFO whenever it is free or being
  // taken, so back-to-back bytes go out at one per cycle.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_pop) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_rdata;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
        r_tx_data  <= '0;
      end
      if (w_push) begin
        r_rr_ptr <= RR_W'(rr_next(int'(w_gidx), NREQ));
      end
    end
  end

  assign req_ready = w_grant;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign fifo_full = w_fifo_full;
  assign tx_idle   = w_fifo_empty & ~r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_tx_sched                                           |
// | Purpose : Self-checking bench for uart_tx_sched. A queue-based       |
// |           reference model predicts grants, occupancy and the output  |
// |           register; a scoreboard checks every byte the PHY accepts.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_uart_tx_sched;

  localparam int NREQ  = 2;
  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic              clka = 1'b0;
  logic              rst;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              tx_idle;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: bytes in the order they were accepted from producers.
  logic [7:0] exp_q[$];

  // Reference model: FIFO contents, output register, round-robin start.
  logic [7:0] m_fifo[$];
  logic       m_valid;
  logic [7:0] m_data;
  int         m_rr;

  uart_tx_sched #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clka       (clka),
    .rst        (rst),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .tx_idle    (tx_idle)
  );

  always #5 clka = ~clka;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change only just after the rising edge.
  task automatic cyc();
    @(posedge clka);
    #2;
  endtask

  // Reference model, evaluated mid-cycle: checks the current outputs, then
  // predicts what the next rising edge does with the current inputs.
  always @(negedge clka) begin
    int g;
    int idx;
    logic [NREQ-1:0] erdy;
    logic [7:0] b;
    if (rst) begin
      m_fifo.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_rr    = 0;
    end
    g = -1;
    if (m_fifo.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    chk("req_ready", req_ready, erdy);
    chk("fifo_level", fifo_level, m_fifo.size());
    chk("fifo_full", fifo_full, m_fifo.size() == DEPTH);
    chk("tx_idle", tx_idle, (m_fifo.size() == 0) && !m_valid);
    chk("tx_valid", tx_valid, m_valid);
    chk("tx_data", tx_data, m_data);
    if (!rst) begin
      if (m_fifo.size() > 0 && (!m_valid || tx_ready)) begin
        m_data  = m_fifo.pop_front();
        m_valid = 1'b1;
      end else if (tx_ready) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
      end
      if (g >= 0) begin
        b = req_data[8*g +: 8];
        m_fifo.push_back(b);
        exp_q.push_back(b);
        m_rr = (g + 1) % NREQ;
      end
    end
  end

  // Monitor: every byte the PHY takes must be the oldest accepted byte.
  always @(negedge clka) begin
    if (rst) begin
      exp_q.delete();
    end else if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_byte: got %0h expected none at t=%0t", tx_data, $time);
      end else begin
        chk("sb_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int guard;
    logic hs;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("t1_idle", tx_idle, 1'b1);
    chk("t1_ready", req_ready, 2'b00);

    // Single byte from requester 0.
    tx_ready  = 1'b1;
    req_data  = 16'h0041;
    req_valid = 2'b01;
    #1 chk("t2_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #1 chk("t2_not_yet", tx_valid, 1'b0);
    cyc();
    #1 chk("t2_txv", tx_valid, 1'b1);
    chk("t2_txd", tx_data, 8'h41);
    cyc();
    #1 chk("t2_idle_after", tx_idle, 1'b1);

    // Both requesters continuously: grants alternate, starting with 1.
    req_data  = 16'h2010;
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_grant", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    req_valid = 2'b00;
    repeat (5) cyc();

    // Fill with the PHY stalled: 1 in the output register, 16 in the FIFO.
    tx_ready = 1'b0;
    n = 0;
    guard = 0;
    while (n < 17 && guard < 100) begin
      req_data  = {8'h00, 8'(n)};
      req_valid = 2'b01;
      @(negedge clka);
      hs = req_ready[0];
      cyc();
      if (hs) n++;
      guard++;
    end
    chk("t4_accepted", n, 17);
    req_data = 16'h0011;
    cyc();
    #1 chk("t4_full", fifo_full, 1'b1);
    chk("t4_level", fifo_level, 16);
    chk("t4_no_grant", req_ready, 2'b00);
    chk("t4_txd", tx_data, 8'h00);

    // Pop at full: no accept in the same cycle, accept on the next.
    tx_ready = 1'b1;
    #1 chk("t5_no_accept", req_ready, 2'b00);
    cyc();
    tx_ready = 1'b0;
    #1 chk("t5_level15", fifo_level, 15);
    chk("t5_accept", req_ready, 2'b01);
    cyc();
    #1 chk("t5_level16", fifo_level, 16);
    req_valid = 2'b00;
    tx_ready  = 1'b1;
    repeat (25) cyc();
    chk("t4_drained", tx_idle, 1'b1);

    // Reset with bytes queued and the output register loaded.
    tx_ready = 1'b0;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 50) begin
      req_data  = {8'hA0 + 8'(n), 8'h00};
      req_valid = 2'b10;
      @(negedge clka);
      hs = req_ready[1];
      cyc();
      if (hs) n++;
      guard++;
    end
    req_valid = 2'b00;
    cyc();
    #1 chk("t6_pre_valid", tx_valid, 1'b1);
    chk("t6_pre_level", fifo_level, 4);
    rst = 1'b1;
    #1 chk("t6_async_valid", tx_valid, 1'b0);
    chk("t6_async_level", fifo_level, 0);
    chk("t6_async_idle", tx_idle, 1'b1);
    repeat (2) cyc();
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (6) cyc();

    // Randomised traffic: slow PHY first so the FIFO fills, then mixed.
    for (int c = 0; c < 600; c++) begin
      req_valid = 2'($urandom);
      req_data  = 16'($urandom);
      tx_ready  = (c < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      cyc();
    end

    req_valid = 2'b00;
    tx_ready  = 1'b1;
    guard = 0;
    while (!tx_idle && guard < 40) begin
      cyc();
      guard++;
    end
    cyc();
    chk("final_idle", tx_idle, 1'b1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
